// File: rtl/ham_pkg.sv
// Shared Hamming(17,12) definitions: sizes, parity positions, FSM state type and
// the data-to-codeword map also used on the decoder side.
package ham_pkg;

   localparam int CW_W   = 17;
   localparam int DATA_W = 12;
   localparam int NPAR   = 5;

   localparam int PAR_IDX [NPAR] = '{0, 1, 3, 7, 15};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   // Even parity; parity k covers every codeword index whose (index+1) has bit k set.
   function automatic logic [CW_W-1:0] ham_encode(input logic [DATA_W-1:0] d);
      logic [CW_W-1:0] cw;
      logic [NPAR-1:0] par;
      cw        = '0;
      cw[2]     = d[0];
      cw[6:4]   = d[3:1];
      cw[14:8]  = d[10:4];
      cw[16]    = d[11];
      par[0] = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10] ^ cw[12] ^ cw[14] ^ cw[16];
      par[1] = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10] ^ cw[13] ^ cw[14];
      par[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[11] ^ cw[12] ^ cw[13] ^ cw[14];
      par[3] = ^cw[14:8];
      par[4] = cw[16];
      for (int k = 0; k < NPAR; k++) cw[PAR_IDX[k]] = par[k];
      return cw;
   endfunction

endpackage

// File: rtl/ham_enc_core.sv
// Combinational Hamming(17,12) encoder with optional single-bit error injection.
module ham_enc_core
   import ham_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [4:0]        inj_pos_i,
   output logic [CW_W-1:0]   cw_o
);

   logic             inj_en;
   logic [CW_W-1:0]  flip;

   // Positions outside 1..17 mean no injection.
   assign inj_en = (inj_pos_i >= 5'd1) && (inj_pos_i <= 5'd17);
   assign flip   = inj_en ? (CW_W'(1) << (inj_pos_i - 5'd1)) : '0;
   assign cw_o   = ham_encode(data_i) ^ flip;

endmodule

// File: rtl/ham_enc_tx.sv
// Hamming(17,12) encoder and bit-serial transmitter with frame strobes and
// optional inter-frame gap.
module ham_enc_tx
   import ham_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1,
   parameter int IFG       = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [4:0]        inj_pos,
   input  logic              tx_ready,
   output logic              tx_valid,
   output logic              tx_bit,
   output logic              tx_sof,
   output logic              tx_eof,
   output logic [CW_W-1:0]   cw_out,
   output logic              busy
);

   tx_state_e        state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [3:0]       gap_q, gap_d;
   logic [CW_W-1:0]  sh_q, sh_d;
   logic [CW_W-1:0]  cw_q, cw_d;
   logic [CW_W-1:0]  cw_enc;
   logic             last_beat;
   logic             cur_bit;

   ham_enc_core u_core (
      .data_i    (in_data),
      .inj_pos_i (inj_pos),
      .cw_o      (cw_enc)
   );

   assign last_beat = (cnt_q == 5'd16);
   assign cur_bit   = LSB_FIRST ? sh_q[0] : sh_q[CW_W-1];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gap_d    = gap_q;
      sh_d     = sh_q;
      cw_d     = cw_q;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
         end
         ST_SHIFT: begin
            if (tx_ready) begin
               if (!last_beat) begin
                  cnt_d = cnt_q + 5'd1;
                  sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
               end else if (IFG > 0) begin
                  state_d = ST_GAP;
                  gap_d   = '0;
               end else begin
                  // Closing beat frees the shifter, so a new word may load with no bubble.
                  state_d  = ST_IDLE;
                  in_ready = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == 4'(IFG - 1)) state_d = ST_IDLE;
            else                      gap_d   = gap_q + 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (in_ready && in_valid) begin
         state_d = ST_SHIFT;
         cnt_d   = '0;
         sh_d    = cw_enc;
         cw_d    = cw_enc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
         sh_q    <= '0;
         cw_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         sh_q    <= sh_d;
         cw_q    <= cw_d;
      end
   end

   assign tx_valid = (state_q == ST_SHIFT);
   assign tx_bit   = tx_valid & cur_bit;
   assign tx_sof   = tx_valid & (cnt_q == 5'd0);
   assign tx_eof   = tx_valid & last_beat;
   assign cw_out   = cw_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ham_enc_tx.sv
// Bench for ham_enc_tx: behavioural Hamming model plus per-cycle stream scoreboard
// (LSB-first, no gap) and a directed MSB-first instance with a 3-cycle gap.
module tb_ham_enc_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0, in_ready, tx_ready = 1'b0;
   logic [11:0] in_data = '0;
   logic [4:0]  inj_pos = '0;
   logic        tx_valid, tx_bit, tx_sof, tx_eof, busy;
   logic [16:0] cw_out;

   logic        v2 = 1'b0, in_ready2, tr2 = 1'b1;
   logic [11:0] d2 = '0;
   logic [4:0]  inj2 = '0;
   logic        tx_valid2, tx_bit2, tx_sof2, tx_eof2, busy2;
   logic [16:0] cw_out2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ham_enc_tx #(.LSB_FIRST(1'b1), .IFG(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .inj_pos(inj_pos), .tx_ready(tx_ready),
      .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_sof(tx_sof), .tx_eof(tx_eof),
      .cw_out(cw_out), .busy(busy)
   );

   ham_enc_tx #(.LSB_FIRST(1'b0), .IFG(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(in_ready2),
      .in_data(d2), .inj_pos(inj2), .tx_ready(tr2),
      .tx_valid(tx_valid2), .tx_bit(tx_bit2), .tx_sof(tx_sof2), .tx_eof(tx_eof2),
      .cw_out(cw_out2), .busy(busy2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Textbook Hamming: data fills non-power-of-two positions in order; parity at
   // position p is the xor of every other position whose number has bit p set.
   function automatic logic [16:0] model_cw(input logic [11:0] d, input logic [4:0] inj);
      logic [16:0] cw;
      int j;
      logic par;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos <= 17; pos++)
         if ((pos & (pos - 1)) != 0) begin
            cw[pos-1] = d[j];
            j++;
         end
      for (int p = 1; p <= 16; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos <= 17; pos++)
            if ((pos & p) != 0 && pos != p) par ^= cw[pos-1];
         cw[p-1] = par;
      end
      if (inj >= 5'd1 && inj <= 5'd17) cw[inj-1] = ~cw[inj-1];
      return cw;
   endfunction

   // Expected serial stream of u_dut: {bit, sof, eof} per beat.
   logic [2:0]  q[$];
   logic [16:0] exp_cw = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         exp_cw = '0;
         chk("rst_tx_valid", 32'(tx_valid), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_in_ready", 32'(in_ready), 32'd1);
         chk("rst_cw_out", 32'(cw_out), 32'd0);
         chk("rst_strobes", 32'({tx_bit, tx_sof, tx_eof}), 32'd0);
      end else begin
         chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
         chk("busy", 32'(busy), 32'(q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || (q.size() == 1 && tx_ready)));
         chk("cw_out", 32'(cw_out), 32'(exp_cw));
         if (q.size() > 0) chk("beat", 32'({tx_bit, tx_sof, tx_eof}), 32'(q[0]));
         if (tx_valid && tx_ready && q.size() > 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            exp_cw = model_cw(in_data, inj_pos);
            for (int b = 0; b < 17; b++)
               q.push_back({exp_cw[b], 1'(b == 0), 1'(b == 16)});
         end
      end
   end

   task automatic send1(input logic [11:0] d, input logic [4:0] inj);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      inj_pos  = inj;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      chk("accept_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [16:0] got;
      bit ok;

      chk("model_000", 32'(model_cw(12'h000, 5'd0)), 32'h00000);
      chk("model_fff", 32'(model_cw(12'hFFF, 5'd0)), 32'h1FFFE);
      chk("model_001", 32'(model_cw(12'h001, 5'd0)), 32'h00007);
      chk("model_800", 32'(model_cw(12'h800, 5'd0)), 32'h18001);
      chk("model_inj14", 32'(model_cw(12'h001, 5'd14)), 32'h02007);
      chk("model_inj20", 32'(model_cw(12'h001, 5'd20)), 32'h00007);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tx_ready = 1'b1;

      send1(12'h000, 5'd0);
      wait_idle();
      chk("cw_000", 32'(cw_out), 32'h00000);
      send1(12'hFFF, 5'd0);
      wait_idle();
      chk("cw_fff", 32'(cw_out), 32'h1FFFE);
      send1(12'h001, 5'd0);
      send1(12'h800, 5'd0);
      wait_idle();
      chk("cw_800", 32'(cw_out), 32'h18001);
      send1(12'h001, 5'd14);
      wait_idle();
      chk("cw_inj14", 32'(cw_out), 32'h02007);

      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         tx_ready = ($urandom_range(0, 3) != 0);
         in_valid = ($urandom_range(0, 2) == 0);
         in_data  = 12'($urandom);
         inj_pos  = 5'($urandom);
      end
      in_valid = 1'b0;
      tx_ready = 1'b1;
      wait_idle();

      // Abandon a frame at beat 8.
      send1(12'h5A3, 5'd0);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_tx_valid", 32'(tx_valid), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_cw_out", 32'(cw_out), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send1(12'hFFF, 5'd0);
      wait_idle();
      chk("cw_fff_after_rst", 32'(cw_out), 32'h1FFFE);

      // MSB-first instance with 3-cycle inter-frame gap.
      v2 = 1'b1;
      d2 = 12'h001;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready2) begin ok = 1'b1; break; end
      end
      chk("accept2_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1 v2 = 1'b0;
      got = '0;
      for (int b = 0; b < 17; b++) begin
         @(negedge clk);
         chk("msb_valid", 32'(tx_valid2), 32'd1);
         chk("msb_sof", 32'(tx_sof2), 32'(b == 0));
         chk("msb_eof", 32'(tx_eof2), 32'(b == 16));
         got = {got[15:0], tx_bit2};
      end
      chk("msb_stream", 32'(got), 32'(model_cw(12'h001, 5'd0)));
      chk("msb_cw_out", 32'(cw_out2), 32'h00007);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready2) break;
         chk("gap_busy", 32'({busy2, tx_valid2}), 32'b10);
         n++;
      end
      chk("gap_len", 32'(n), 32'd3);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
